// File: rtl/crc_req_sched.sv
// Round-robin scheduler sharing one CRC engine among NUM_REQ requesters.
// Define CRC_SCHED_WATCHDOG_EN to enable the engine-response watchdog (rsp_timeout).
module crc_req_sched #(
  parameter  int NUM_REQ = 4,
  parameter  int MSG_W   = 60,
  parameter  int TIMEOUT = 64,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk_1,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_mode,
  input  logic [NUM_REQ-1:0]       req_crc,
  input  logic [NUM_REQ*MSG_W-1:0] req_msg,
  output logic                     eng_in_valid,
  output logic                     eng_mode,
  output logic                     eng_crc,
  output logic [MSG_W-1:0]         eng_message,
  input  logic                     eng_out_valid,
  input  logic [MSG_W-1:0]         eng_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [MSG_W-1:0]         rsp_data,
  output logic                     rsp_timeout,
  output logic                     err_spurious
);

  // state | meaning
  // IDLE  | arbitrate, grant one requester
  // ISSUE | one-cycle start pulse to the engine
  // WAIT  | wait for the engine result (or watchdog expiry)
  // RESP  | hold the response until it is accepted
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  last_q, last_d, id_q, id_d;
  logic             mode_q, mode_d, crc_q, crc_d;
  logic             to_q, to_d, spur_q, spur_d;
  logic [MSG_W-1:0] msg_q, msg_d, data_q, data_d;
  logic             gnt_found;
  logic [ID_W-1:0]  gnt_idx, cand;
  logic             wd_hit;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

`ifdef CRC_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  // Expire on the WAIT cycle whose incremented count reaches TIMEOUT-1, so the
  // timeout response appears TIMEOUT cycles after the start pulse.
  assign wd_hit = (wd_q + WD_W'(1)) == WD_W'(TIMEOUT - 1);

  always_comb begin
    wd_d = wd_q;
    if (state_q == ST_ISSUE)     wd_d = '0;
    else if (state_q == ST_WAIT) wd_d = wd_q + WD_W'(1);
  end

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    mode_d    = mode_q;
    crc_d     = crc_q;
    msg_d     = msg_q;
    data_d    = data_q;
    to_d      = to_q;
    spur_d    = spur_q | (eng_out_valid & (state_q != ST_WAIT));
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          id_d    = gnt_idx;
          mode_d  = req_mode[gnt_idx];
          crc_d   = req_crc[gnt_idx];
          msg_d   = req_msg[gnt_idx*MSG_W +: MSG_W];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // A result arriving on the expiry cycle takes precedence.
        if (eng_out_valid) begin
          data_d  = eng_out;
          to_d    = 1'b0;
          state_d = ST_RESP;
        end else if (wd_hit) begin
          data_d  = '0;
          to_d    = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          last_d  = id_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      mode_q  <= 1'b0;
      crc_q   <= 1'b0;
      msg_q   <= '0;
      data_q  <= '0;
      to_q    <= 1'b0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      mode_q  <= mode_d;
      crc_q   <= crc_d;
      msg_q   <= msg_d;
      data_q  <= data_d;
      to_q    <= to_d;
      spur_q  <= spur_d;
    end
  end

  assign eng_in_valid = (state_q == ST_ISSUE);
  assign eng_mode     = mode_q;
  assign eng_crc      = crc_q;
  assign eng_message  = msg_q;
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_id       = id_q;
  assign rsp_data     = data_q;
  assign rsp_timeout  = to_q;
  assign err_spurious = spur_q;

endmodule

// File: tb/tb_crc_req_sched.sv
// Self-checking bench for crc_req_sched: cycle-timeline job model plus directed scenarios.
// Watchdog scenario adapts to whether CRC_SCHED_WATCHDOG_EN is defined.
module tb_crc_req_sched;
  localparam int NUM_REQ = 4;
  localparam int MSG_W   = 60;
  localparam int TIMEOUT = 16;
`ifdef CRC_SCHED_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic                     clk_1 = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid, req_ready, req_mode, req_crc;
  logic [NUM_REQ*MSG_W-1:0] req_msg;
  logic                     eng_in_valid, eng_mode, eng_crc;
  logic [MSG_W-1:0]         eng_message;
  logic                     eng_out_valid;
  logic [MSG_W-1:0]         eng_out;
  logic                     rsp_valid, rsp_ready, rsp_timeout, err_spurious;
  logic [1:0]               rsp_id;
  logic [MSG_W-1:0]         rsp_data;

  crc_req_sched #(.NUM_REQ(NUM_REQ), .MSG_W(MSG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_1(clk_1), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_crc(req_crc), .req_msg(req_msg),
    .eng_in_valid(eng_in_valid), .eng_mode(eng_mode), .eng_crc(eng_crc),
    .eng_message(eng_message), .eng_out_valid(eng_out_valid), .eng_out(eng_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .err_spurious(err_spurious)
  );

  initial forever #5 clk_1 = ~clk_1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // engine model controls
  bit              eng_en = 1'b1;
  bit              eng_fixed_on = 1'b0;
  logic [MSG_W-1:0] eng_fixed = '0;
  int              eng_lat = 5;
  int              eng_due = -1;
  int              spur_at = -1;
  logic [MSG_W-1:0] eng_resp = '0;

  // observation log
  int              gq[$];
  int              issue_cnt = 0;
  int              issue_cyc = 0;
  logic [MSG_W-1:0] issue_msg = '0;
  logic            issue_mode = 1'b0, issue_crc = 1'b0;

  // job-timeline model
  bit              m_busy = 0, m_done = 0, m_spur = 0, m_mode = 0, m_crc = 0, m_to = 0;
  int              m_last = NUM_REQ - 1, m_id = 0, m_issue = 0, m_resp_at = 0;
  logic [MSG_W-1:0] m_msg = '0, m_data = '0;

  logic [MSG_W-1:0] msg_tab [NUM_REQ] = '{60'h0123456789ABCDE, 60'h111122223333444,
                                          60'hFEDCBA987654321, 60'h0F0F0F0F0F0F0F0};

  function automatic logic [MSG_W-1:0] eng_f(input logic [MSG_W-1:0] m);
    return {m[29:0], m[59:30]} ^ 60'h5A5A5A5A5A5A5A5;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired without the awaited event (cycle %0d)", name, cyc);
  endtask

  // engine: answers eng_due, or injects an unsolicited result at spur_at
  initial begin : engine
    eng_out_valid = 1'b0;
    eng_out       = '0;
    forever begin
      @(posedge clk_1); #1;
      cyc++;
      eng_out_valid = 1'b0;
      eng_out       = '0;
      if (cyc == eng_due) begin
        eng_out_valid = 1'b1;
        eng_out       = eng_resp;
      end else if (cyc == spur_at) begin
        eng_out_valid = 1'b1;
        eng_out       = '1;
      end
    end
  end

  always @(negedge clk_1) begin : cmp_blk
    logic [NUM_REQ-1:0] e_ready;
    bit e_inv, e_rv, waiting;
    int pick;
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_spur = 0; m_mode = 0; m_crc = 0; m_to = 0;
      m_last = NUM_REQ - 1; m_id = 0; m_msg = '0; m_data = '0;
      eng_due = -1;
    end else begin
      pick = -1;
      if (!m_busy)
        for (int k = 1; k <= NUM_REQ; k++)
          if (pick < 0 && req_valid[(m_last + k) % NUM_REQ] == 1'b1) pick = (m_last + k) % NUM_REQ;
      e_ready = '0;
      if (pick >= 0) e_ready[pick] = 1'b1;
      e_inv   = m_busy && (cyc == m_issue);
      e_rv    = m_busy && m_done && (cyc >= m_resp_at);
      waiting = m_busy && !m_done && (cyc > m_issue);

      chk("req_ready", 64'(req_ready), 64'(e_ready));
      chk("eng_in_valid", 64'(eng_in_valid), 64'(e_inv));
      chk("eng_mode", 64'(eng_mode), 64'(m_mode));
      chk("eng_crc", 64'(eng_crc), 64'(m_crc));
      chk("eng_message", 64'(eng_message), 64'(m_msg));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      chk("err_spurious", 64'(err_spurious), 64'(m_spur));
      if (e_rv) begin
        chk("rsp_id", 64'(rsp_id), 64'(m_id));
        chk("rsp_data", 64'(rsp_data), 64'(m_data));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(m_to));
      end

      for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) gq.push_back(k);
      if (eng_in_valid) begin
        issue_cnt++;
        issue_cyc  = cyc;
        issue_msg  = eng_message;
        issue_mode = eng_mode;
        issue_crc  = eng_crc;
        if (eng_en) begin
          eng_due  = cyc + eng_lat;
          eng_resp = eng_fixed_on ? eng_fixed : eng_f(eng_message);
        end
      end

      if (eng_out_valid && !waiting) m_spur = 1;
      if (waiting) begin
        if (eng_out_valid) begin
          m_done = 1; m_resp_at = cyc + 1; m_data = eng_out; m_to = 0;
        end else if (WD_ON && cyc == m_issue + TIMEOUT - 1) begin
          m_done = 1; m_resp_at = cyc + 1; m_data = '0; m_to = 1;
        end
      end else if (!m_busy && pick >= 0) begin
        m_busy  = 1;
        m_done  = 0;
        m_id    = pick;
        m_mode  = req_mode[pick];
        m_crc   = req_crc[pick];
        m_msg   = req_msg[pick*MSG_W +: MSG_W];
        m_issue = cyc + 1;
      end else if (e_rv && rsp_ready) begin
        m_busy = 0;
        m_last = m_id;
      end
    end
  end

  task automatic tick();
    @(posedge clk_1); #2;
  endtask

  task automatic wait_grant(input int lim, output int id);
    id = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk_1); #1;
      if (req_ready != '0) begin
        for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) id = k;
        return;
      end
    end
    timeout_fail("wait_grant");
  endtask

  task automatic wait_rsp(input int lim, output int rc);
    rc = -1000;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk_1); #1;
      if (rsp_valid) begin
        rc = cyc;
        return;
      end
    end
    timeout_fail("wait_rsp");
  endtask

  task automatic wait_gq(input int n, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (gq.size() >= n) return;
      @(negedge clk_1); #1;
    end
    timeout_fail("wait_gq");
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_eng_in_valid"}, 64'(eng_in_valid), 64'(0));
    chk({tag, "_eng_mode"}, 64'(eng_mode), 64'(0));
    chk({tag, "_eng_crc"}, 64'(eng_crc), 64'(0));
    chk({tag, "_eng_message"}, 64'(eng_message), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'(0));
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
    chk({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'(0));
    chk({tag, "_err_spurious"}, 64'(err_spurious), 64'(0));
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin : global_guard
    #100000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  initial begin : stim
    int id, rc, cnt0, seen;
    int exp_order[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 3};
    rst_n     = 1'b1;
    req_valid = '0;
    req_mode  = '0;
    req_crc   = '0;
    req_msg   = {msg_tab[3], msg_tab[2], msg_tab[1], msg_tab[0]};
    rsp_ready = 1'b1;
    #3 rst_n = 1'b0;
    #1 check_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;

    // single job from requester 0
    eng_fixed_on = 1'b1;
    eng_fixed    = 60'h0FEDCBA98765432;
    eng_lat      = 5;
    cnt0         = issue_cnt;
    req_valid    = 4'b0001;
    wait_grant(20, id);
    chk("single_grant", 64'(id), 64'(0));
    tick();
    req_valid = '0;
    wait_rsp(30, rc);
    chk("single_rsp_id", 64'(rsp_id), 64'(0));
    chk("single_rsp_data", 64'(rsp_data), 64'(60'h0FEDCBA98765432));
    chk("single_rsp_timeout", 64'(rsp_timeout), 64'(0));
    chk("single_latency", 64'(rc - issue_cyc), 64'(6));
    chk("single_pulses", 64'(issue_cnt - cnt0), 64'(1));
    chk("single_eng_msg", 64'(issue_msg), 64'(60'h0123456789ABCDE));
    chk("single_eng_mode", 64'(issue_mode), 64'(0));
    chk("single_eng_crc", 64'(issue_crc), 64'(0));
    eng_fixed_on = 1'b0;
    tick();

    // fairness
    do_reset();
    gq.delete();
    eng_lat   = 2;
    req_mode  = 4'b0101;
    req_crc   = 4'b0011;
    req_valid = 4'b1111;
    wait_gq(8, 200);
    tick();
    req_valid = 4'b1010;
    wait_gq(10, 60);
    tick();
    req_valid = '0;
    for (int i = 0; i < 10; i++)
      chk($sformatf("fair_order_%0d", i), 64'((i < gq.size()) ? gq[i] : -1), 64'(exp_order[i]));
    wait_rsp(20, rc);
    tick();

    // backpressure on the response channel
    rsp_ready = 1'b0;
    eng_lat   = 3;
    req_valid = 4'b0100;
    wait_grant(20, id);
    chk("bp_grant", 64'(id), 64'(2));
    tick();
    req_valid = '0;
    wait_rsp(20, rc);
    tick();
    req_valid = 4'b0101;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_1); #1;
      chk("bp_hold_valid", 64'(rsp_valid), 64'(1));
      chk("bp_hold_id", 64'(rsp_id), 64'(2));
      chk("bp_hold_data", 64'(rsp_data), 64'(eng_f(msg_tab[2])));
      chk("bp_hold_ready", 64'(req_ready), 64'(0));
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk_1); #1;
    chk("bp_last_valid", 64'(rsp_valid), 64'(1));
    chk("bp_last_ready", 64'(req_ready), 64'(0));
    @(negedge clk_1); #1;
    chk("bp_next_grant", 64'(req_ready), 64'(4'b0001));
    chk("bp_next_valid", 64'(rsp_valid), 64'(0));
    tick();
    req_valid = '0;
    wait_rsp(20, rc);
    tick();

    // silent engine
    rsp_ready = 1'b0;
    eng_en    = 1'b0;
    req_valid = 4'b1000;
    wait_grant(20, id);
    chk("wd_grant", 64'(id), 64'(3));
    tick();
    req_valid = '0;
`ifdef CRC_SCHED_WATCHDOG_EN
    wait_rsp(40, rc);
    chk("wd_latency", 64'(rc - issue_cyc), 64'(16));
    chk("wd_timeout", 64'(rsp_timeout), 64'(1));
    chk("wd_data", 64'(rsp_data), 64'(0));
`else
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_1); #1;
      if (rsp_valid) seen++;
    end
    chk("nowd_silent", 64'(seen), 64'(0));
    tick();
    spur_at = cyc + 1;
    wait_rsp(5, rc);
    chk("nowd_timeout", 64'(rsp_timeout), 64'(0));
    chk("nowd_data", 64'(rsp_data), 64'(60'hFFFFFFFFFFFFFFF));
`endif
    chk("late_spur_before", 64'(err_spurious), 64'(0));
    tick();
    spur_at = cyc + 1;
    repeat (3) @(negedge clk_1);
    #1;
    chk("late_spur_after", 64'(err_spurious), 64'(1));
    chk("late_spur_rsp_held", 64'(rsp_valid), 64'(1));
    tick();
    rsp_ready = 1'b1;
    tick();
    tick();

    // reset in the middle of WAIT
    req_valid = 4'b0010;
    wait_grant(20, id);
    chk("mid_grant", 64'(id), 64'(1));
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1 check_zero("mid_rst");
    tick();
    rst_n     = 1'b1;
    eng_en    = 1'b1;
    req_valid = 4'b0101;
    wait_grant(20, id);
    chk("post_rst_first", 64'(id), 64'(0));
    chk("post_rst_spur", 64'(err_spurious), 64'(0));
    tick();
    req_valid = 4'b0100;
    wait_grant(40, id);
    chk("post_rst_second", 64'(id), 64'(2));
    tick();
    req_valid = '0;
    wait_rsp(20, rc);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
